// File: rtl/double_adder_arbiter_if.sv
// Handshake and data bundle between the arbiter, its N_REQ clients and one double_adder.
// master = arbiter side, slave = clients plus adder side.
interface double_adder_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [64*N_REQ-1:0] req_a;
    logic [64*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]    req_stb;
    logic [N_REQ-1:0]    req_ack;
    logic [63:0]         resp_z;
    logic [N_REQ-1:0]    resp_stb;
    logic [N_REQ-1:0]    resp_ack;
    logic [63:0]         adder_a;
    logic                adder_a_stb;
    logic                adder_a_ack;
    logic [63:0]         adder_b;
    logic                adder_b_stb;
    logic                adder_b_ack;
    logic [63:0]         adder_z;
    logic                adder_z_stb;
    logic                adder_z_ack;

    modport master (
        input  req_a, req_b, req_stb, resp_ack,
        input  adder_a_ack, adder_b_ack, adder_z, adder_z_stb,
        output req_ack, resp_z, resp_stb,
        output adder_a, adder_a_stb, adder_b, adder_b_stb, adder_z_ack
    );

    modport slave (
        output req_a, req_b, req_stb, resp_ack,
        output adder_a_ack, adder_b_ack, adder_z, adder_z_stb,
        input  req_ack, resp_z, resp_stb,
        input  adder_a, adder_a_stb, adder_b, adder_b_stb, adder_z_ack
    );
endinterface

// File: rtl/double_adder_arbiter.sv
// Round-robin arbiter sharing a single double_adder among N_REQ requesters,
// one operation in flight at a time; every output is registered.
module double_adder_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    double_adder_arbiter_if.master bus,
    output logic [IDX_W-1:0]      o_grant_idx,
    output logic                  o_busy,
    output logic [31:0]           o_op_count
);
    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_SEND_A, S_SEND_B, S_WAIT_Z, S_RESP
    } state_t;

    state_t             r_state, w_state_next;
    logic [IDX_W-1:0]   r_last, w_last_next;
    logic [IDX_W-1:0]   r_grant, w_grant_next;
    logic [N_REQ-1:0]   r_req_ack, w_req_ack_next;
    logic [N_REQ-1:0]   r_resp_stb, w_resp_stb_next;
    logic [63:0]        r_resp_z, w_resp_z_next;
    logic [63:0]        r_adder_a, w_adder_a_next;
    logic [63:0]        r_adder_b, w_adder_b_next;
    logic               r_a_stb, w_a_stb_next;
    logic               r_b_stb, w_b_stb_next;
    logic               r_z_ack, w_z_ack_next;
    logic               r_busy, w_busy_next;
    logic [31:0]        r_op_count, w_op_count_next;

    // Requester indices in round-robin order starting just after the last winner.
    logic [IDX_W-1:0]   w_rot_idx [N_REQ];
    logic [N_REQ-1:0]   w_rot_req;
    logic               w_any;
    logic [IDX_W-1:0]   w_win;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        logic [IDX_W+1:0] w_sum;
        assign w_sum = {2'b00, r_last} + (IDX_W+2)'(gi + 1);
        assign w_rot_idx[gi] = (w_sum >= (IDX_W+2)'(N_REQ)) ?
                               IDX_W'(w_sum - (IDX_W+2)'(N_REQ)) : IDX_W'(w_sum);
        assign w_rot_req[gi] = bus.req_stb[w_rot_idx[gi]];
    end

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot_req[i]) begin
                w_any = 1'b1;
                w_win = w_rot_idx[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last     <= IDX_W'(N_REQ - 1);
            r_grant    <= '0;
            r_req_ack  <= '0;
            r_resp_stb <= '0;
            r_resp_z   <= '0;
            r_adder_a  <= '0;
            r_adder_b  <= '0;
            r_a_stb    <= 1'b0;
            r_b_stb    <= 1'b0;
            r_z_ack    <= 1'b0;
            r_busy     <= 1'b0;
            r_op_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_last     <= w_last_next;
            r_grant    <= w_grant_next;
            r_req_ack  <= w_req_ack_next;
            r_resp_stb <= w_resp_stb_next;
            r_resp_z   <= w_resp_z_next;
            r_adder_a  <= w_adder_a_next;
            r_adder_b  <= w_adder_b_next;
            r_a_stb    <= w_a_stb_next;
            r_b_stb    <= w_b_stb_next;
            r_z_ack    <= w_z_ack_next;
            r_busy     <= w_busy_next;
            r_op_count <= w_op_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any) w_state_next = S_GRANT;
            S_GRANT:  w_state_next = bus.req_stb[r_grant] ? S_SEND_A : S_IDLE;
            S_SEND_A: if (r_a_stb && bus.adder_a_ack) w_state_next = S_SEND_B;
            S_SEND_B: if (r_b_stb && bus.adder_b_ack) w_state_next = S_WAIT_Z;
            S_WAIT_Z: if (r_z_ack && bus.adder_z_stb) w_state_next = S_RESP;
            S_RESP:   if (bus.resp_ack[r_grant]) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Registered outputs; a withdrawn grant leaves last and op_count untouched.
    always_comb begin
        w_last_next     = r_last;
        w_grant_next    = r_grant;
        w_req_ack_next  = r_req_ack;
        w_resp_stb_next = r_resp_stb;
        w_resp_z_next   = r_resp_z;
        w_adder_a_next  = r_adder_a;
        w_adder_b_next  = r_adder_b;
        w_a_stb_next    = r_a_stb;
        w_b_stb_next    = r_b_stb;
        w_z_ack_next    = r_z_ack;
        w_op_count_next = r_op_count;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_next   = w_win;
                    w_req_ack_next = N_REQ'(1) << w_win;
                end
            end
            S_GRANT: begin
                w_req_ack_next = '0;
                if (bus.req_stb[r_grant]) begin
                    w_adder_a_next = bus.req_a[{r_grant, 6'd0} +: 64];
                    w_adder_b_next = bus.req_b[{r_grant, 6'd0} +: 64];
                    w_a_stb_next   = 1'b1;
                end
            end
            S_SEND_A: begin
                if (r_a_stb && bus.adder_a_ack) begin
                    w_a_stb_next = 1'b0;
                    w_b_stb_next = 1'b1;
                end
            end
            S_SEND_B: begin
                if (r_b_stb && bus.adder_b_ack) begin
                    w_b_stb_next = 1'b0;
                    w_z_ack_next = 1'b1;
                end
            end
            S_WAIT_Z: begin
                if (r_z_ack && bus.adder_z_stb) begin
                    w_resp_z_next   = bus.adder_z;
                    w_z_ack_next    = 1'b0;
                    w_resp_stb_next = N_REQ'(1) << r_grant;
                end
            end
            S_RESP: begin
                if (bus.resp_ack[r_grant]) begin
                    w_resp_stb_next = '0;
                    w_last_next     = r_grant;
                    w_op_count_next = r_op_count + 32'd1;
                end
            end
            default: ;
        endcase
    end

    assign w_busy_next = (w_state_next != S_IDLE);

    assign bus.req_ack     = r_req_ack;
    assign bus.resp_stb    = r_resp_stb;
    assign bus.resp_z      = r_resp_z;
    assign bus.adder_a     = r_adder_a;
    assign bus.adder_b     = r_adder_b;
    assign bus.adder_a_stb = r_a_stb;
    assign bus.adder_b_stb = r_b_stb;
    assign bus.adder_z_ack = r_z_ack;
    assign o_grant_idx     = r_grant;
    assign o_busy          = r_busy;
    assign o_op_count      = r_op_count;
endmodule
